view_matrix_gen: RTL and testbench

//  Sequential generator of the 4x4 camera view matrix V = Ry(yaw) * T(-eye), in fixed point.

---
 rtl/view_pkg.sv | 89 ++++++++
 rtl/view_matrix_gen_if.sv | 26 ++
 rtl/view_mul_sat.sv | 20 ++
 rtl/view_matrix_gen.sv | 176 +++++++++++++++++
 tb/tb_view_matrix_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/view_pkg.sv
// Shared widths, types and fixed-point helpers for view_matrix_gen.
// Optional yaw rotation is enabled by defining VIEW_ROT_EN (see view_matrix_gen.sv).
package view_pkg;

  localparam int WII = 8;
  localparam int WIF = 8;
  localparam int WOI = 8;
  localparam int WOF = 8;

  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;
  // Wide enough for a full-precision product plus any up-shift and a sign guard.
  localparam int SW = 2 * WI + WO + 2;

  typedef logic signed [WI-1:0] in_t;
  typedef logic signed [WO-1:0] entry_t;
  typedef entry_t [15:0]        mat_t;
  typedef logic signed [SW-1:0] wide_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    SUM,
    HOLD
  } state_e;

  typedef struct packed {
    logic   ovf;
    entry_t val;
  } sat_t;

  localparam entry_t ONE  = entry_t'(1 <<< WOF);
  localparam entry_t ZERO = '0;

  localparam wide_t W_ONE   = wide_t'(1);
  localparam wide_t SAT_MAX = wide_t'((64'sd1 <<< (WO - 1)) - 64'sd1);
  localparam wide_t SAT_MIN = ~SAT_MAX;

  // Round-half-up from frac_in fraction bits to WOF, then clamp into Q(WOI.WOF).
  function automatic sat_t sat_resize(input wide_t v, input int frac_in);
    wide_t r;
    sat_t  res;
    r = v;
    if (frac_in > WOF) begin
      r = (r + (W_ONE <<< (frac_in - WOF - 1))) >>> (frac_in - WOF);
    end else if (frac_in < WOF) begin
      r = r <<< (WOF - frac_in);
    end
    res.ovf = (r > SAT_MAX) || (r < SAT_MIN);
    if (r > SAT_MAX) begin
      res.val = SAT_MAX[WO-1:0];
    end else if (r < SAT_MIN) begin
      res.val = SAT_MIN[WO-1:0];
    end else begin
      res.val = r[WO-1:0];
    end
    return res;
  endfunction

  function automatic sat_t in_to_out(input in_t v);
    return sat_resize(wide_t'(v), WIF);
  endfunction

  // Negation happens at full width, so the most-negative code clamps to the most-positive.
  function automatic sat_t neg_sat(input entry_t v);
    return sat_resize(-wide_t'(v), WOF);
  endfunction

  function automatic sat_t neg_in(input in_t v);
    sat_t conv;
    sat_t neg;
    conv    = in_to_out(v);
    neg     = neg_sat(conv.val);
    neg.ovf = neg.ovf | conv.ovf;
    return neg;
  endfunction

  function automatic mat_t identity();
    mat_t m;
    for (int k = 0; k < 16; k++) begin
      m[k] = ((k / 4) == (k % 4)) ? ONE : ZERO;
    end
    return m;
  endfunction

endpackage

// File: rtl/view_matrix_gen_if.sv
// Request/result handshake bundle between the camera registers, view_matrix_gen and the MVP multiplier.
interface view_matrix_gen_if;
  import view_pkg::*;

  logic in_valid;
  logic in_ready;
  in_t  x_pos;
  in_t  y_pos;
  in_t  z_pos;
  in_t  cos_yaw;
  in_t  sin_yaw;
  logic out_valid;
  logic out_ready;
  mat_t view_matrix;
  logic overflow;

  modport master (
    output in_valid, x_pos, y_pos, z_pos, cos_yaw, sin_yaw, out_ready,
    input  in_ready, out_valid, view_matrix, overflow
  );

  modport slave (
    input  in_valid, x_pos, y_pos, z_pos, cos_yaw, sin_yaw, out_ready,
    output in_ready, out_valid, view_matrix, overflow
  );
endinterface

// File: rtl/view_mul_sat.sv
// One signed Q(WII.WIF) x Q(WII.WIF) multiply, rounded to nearest and saturated to Q(WOI.WOF).
module view_mul_sat
  import view_pkg::*;
(
  input  in_t    a_i,
  input  in_t    b_i,
  output entry_t p_o,
  output logic   ovf_o
);

  wide_t prod;
  sat_t  res;

  // Exact: both operands are sign-extended to a width that holds the full product.
  assign prod  = wide_t'(a_i) * wide_t'(b_i);
  assign res   = sat_resize(prod, 2 * WIF);
  assign p_o   = res.val;
  assign ovf_o = res.ovf;

endmodule

// File: rtl/view_matrix_gen.sv
// Camera view matrix V = Ry(yaw) * T(-eye). With VIEW_ROT_EN defined, yaw rotation via one shared
// multiplier (6-edge latency); otherwise translate-only, 1-edge latency, cos/sin ignored.
module view_matrix_gen
  import view_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  view_matrix_gen_if.slave bus
);

  state_e state_q;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   ovf_q;
  mat_t   mat_q;
  logic   accept;

  assign accept          = bus.in_valid && in_ready_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.overflow    = ovf_q;
  assign bus.view_matrix = mat_q;

`ifdef VIEW_ROT_EN
  in_t    x_q, y_q, z_q, c_q, s_q;
  entry_t cx_q, sz_q, sx_q, cz_q;
  in_t    mul_a, mul_b;
  entry_t mul_p;
  logic   mul_ovf;
  mat_t   sum_mat;
  logic   sum_ovf;

  // NOTE: every signal driven from always_comb gets a default first, so no path infers a latch.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL0: begin mul_a = c_q; mul_b = x_q; end
      MUL1: begin mul_a = s_q; mul_b = z_q; end
      MUL2: begin mul_a = s_q; mul_b = x_q; end
      MUL3: begin mul_a = c_q; mul_b = z_q; end
      default: ;
    endcase
  end

  view_mul_sat u_mul (
    .a_i  (mul_a),
    .b_i  (mul_b),
    .p_o  (mul_p),
    .ovf_o(mul_ovf)
  );

  always_comb begin
    sat_t c_e, s_e, ns_e, ny_e, t03_e, t23_e;
    c_e   = in_to_out(c_q);
    s_e   = in_to_out(s_q);
    ns_e  = neg_sat(s_e.val);
    ny_e  = neg_in(y_q);
    t03_e = sat_resize(-(wide_t'(cx_q) + wide_t'(sz_q)), WOF);
    t23_e = sat_resize(wide_t'(sx_q) - wide_t'(cz_q), WOF);

    sum_mat     = identity();
    sum_mat[0]  = c_e.val;
    sum_mat[2]  = s_e.val;
    sum_mat[3]  = t03_e.val;
    sum_mat[7]  = ny_e.val;
    sum_mat[8]  = ns_e.val;
    sum_mat[10] = c_e.val;
    sum_mat[11] = t23_e.val;
    sum_ovf     = c_e.ovf | s_e.ovf | ns_e.ovf | ny_e.ovf | t03_e.ovf | t23_e.ovf;
  end
`else
  mat_t trn_mat;
  logic trn_ovf;
  logic unused_yaw;

  assign unused_yaw = ^{bus.cos_yaw, bus.sin_yaw};

  // NOTE: every signal driven from always_comb gets a default first, so no path infers a latch.
  always_comb begin
    sat_t nx_e, ny_e, nz_e;
    nx_e        = neg_in(bus.x_pos);
    ny_e        = neg_in(bus.y_pos);
    nz_e        = neg_in(bus.z_pos);
    trn_mat     = identity();
    trn_mat[3]  = nx_e.val;
    trn_mat[7]  = ny_e.val;
    trn_mat[11] = nz_e.val;
    trn_ovf     = nx_e.ovf | ny_e.ovf | nz_e.ovf;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      mat_q       <= identity();
`ifdef VIEW_ROT_EN
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      c_q  <= '0;
      s_q  <= '0;
      cx_q <= '0;
      sz_q <= '0;
      sx_q <= '0;
      cz_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
`ifdef VIEW_ROT_EN
            x_q     <= bus.x_pos;
            y_q     <= bus.y_pos;
            z_q     <= bus.z_pos;
            c_q     <= bus.cos_yaw;
            s_q     <= bus.sin_yaw;
            ovf_q   <= 1'b0;
            state_q <= MUL0;
`else
            mat_q       <= trn_mat;
            ovf_q       <= trn_ovf;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
`endif
          end
        end
`ifdef VIEW_ROT_EN
        MUL0: begin
          cx_q    <= mul_p;
          ovf_q   <= ovf_q | mul_ovf;
          state_q <= MUL1;
        end
        MUL1: begin
          sz_q    <= mul_p;
          ovf_q   <= ovf_q | mul_ovf;
          state_q <= MUL2;
        end
        MUL2: begin
          sx_q    <= mul_p;
          ovf_q   <= ovf_q | mul_ovf;
          state_q <= MUL3;
        end
        MUL3: begin
          cz_q    <= mul_p;
          ovf_q   <= ovf_q | mul_ovf;
          state_q <= SUM;
        end
        SUM: begin
          mat_q       <= sum_mat;
          ovf_q       <= ovf_q | sum_ovf;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
`endif
        HOLD: begin
          // in_ready stays low through this edge, so a pending in_valid waits for IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_view_matrix_gen.sv
// Randomized self-checking bench for view_matrix_gen against an integer reference model.
module tb_view_matrix_gen;
  import view_pkg::*;

`ifdef VIEW_ROT_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  bit   m_ovf;

  always #5 clk = ~clk;

  view_matrix_gen_if bus ();

  view_matrix_gen dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] u16(input logic [15:0] v);
    return 256'(v);
  endfunction

  // Reference: plain integer arithmetic in units of 2^-8 (Q8.8 in, Q8.8 out).
  function automatic int sat16(input longint v);
    if (v > 32767) begin
      m_ovf = 1'b1;
      return 32767;
    end
    if (v < -32768) begin
      m_ovf = 1'b1;
      return -32768;
    end
    return int'(v);
  endfunction

  function automatic int rprod(input int a, input int b);
    return sat16((longint'(a) * longint'(b) + 128) >>> 8);
  endfunction

  function automatic mat_t model(input in_t xi, input in_t yi, input in_t zi, input in_t ci, input in_t si);
    int   m[16];
    int   x, y, z, c, s;
    mat_t r;
    x = int'(xi);
    y = int'(yi);
    z = int'(zi);
    c = int'(ci);
    s = int'(si);
    m_ovf = 1'b0;
    for (int k = 0; k < 16; k++) m[k] = (k == 0 || k == 5 || k == 10 || k == 15) ? 256 : 0;
`ifdef VIEW_ROT_EN
    begin
      int cx, sz, sx, cz;
      cx    = rprod(c, x);
      sz    = rprod(s, z);
      sx    = rprod(s, x);
      cz    = rprod(c, z);
      m[0]  = c;
      m[2]  = s;
      m[3]  = sat16(-(longint'(cx) + longint'(sz)));
      m[7]  = sat16(-longint'(y));
      m[8]  = sat16(-longint'(s));
      m[10] = c;
      m[11] = sat16(longint'(sx) - longint'(cz));
    end
`else
    m[3]  = sat16(-longint'(x));
    m[7]  = sat16(-longint'(y));
    m[11] = sat16(-longint'(z));
    if (c == s) m_ovf = m_ovf;
`endif
    for (int k = 0; k < 16; k++) r[k] = entry_t'(m[k]);
    return r;
  endfunction

  function automatic mat_t ident_m();
    mat_t r;
    for (int k = 0; k < 16; k++) r[k] = (k == 0 || k == 5 || k == 10 || k == 15) ? 16'h0100 : 16'h0000;
    return r;
  endfunction

  task automatic scramble();
    bus.x_pos   = 16'($urandom);
    bus.y_pos   = 16'($urandom);
    bus.z_pos   = 16'($urandom);
    bus.cos_yaw = 16'($urandom);
    bus.sin_yaw = 16'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_req(input string tag, input in_t x, input in_t y, input in_t z,
                         input in_t c, input in_t s, input int stall, input bit pulses);
    mat_t exp_m;
    logic exp_o;
    int   lat;
    exp_m = model(x, y, z, c, s);
    exp_o = m_ovf;
    check({tag, "_idle_rdy"}, 256'(bus.in_ready), 256'(1'b1));
    bus.x_pos     = x;
    bus.y_pos     = y;
    bus.z_pos     = z;
    bus.cos_yaw   = c;
    bus.sin_yaw   = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble();
    lat = 1;
    check({tag, "_busy"}, 256'(bus.in_ready), 256'(1'b0));
`ifdef VIEW_ROT_EN
    check({tag, "_ovf_clr"}, 256'(bus.overflow), 256'(1'b0));
`endif
    while (!bus.out_valid && lat < 20) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    bus.out_ready = 1'b0;
    check({tag, "_latency"}, 256'(lat), 256'(LAT));
    check({tag, "_matrix"}, 256'(bus.view_matrix), 256'(exp_m));
    check({tag, "_overflow"}, 256'(bus.overflow), 256'(exp_o));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      scramble();
      @(negedge clk);
      check({tag, "_hold_flags"}, 256'({bus.out_valid, bus.in_ready}), 256'(2'b10));
      check({tag, "_hold_matrix"}, 256'(bus.view_matrix), 256'(exp_m));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, "_done_flags"}, 256'({bus.out_valid, bus.in_ready}), 256'(2'b01));
    check({tag, "_keep_matrix"}, 256'(bus.view_matrix), 256'(exp_m));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_pos     = '0;
    bus.y_pos     = '0;
    bus.z_pos     = '0;
    bus.cos_yaw   = '0;
    bus.sin_yaw   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 256'(bus.in_ready), 256'(1'b1));
    check("rst_out_valid", 256'(bus.out_valid), 256'(1'b0));
    check("rst_overflow", 256'(bus.overflow), 256'(1'b0));
    check("rst_matrix", 256'(bus.view_matrix), 256'(ident_m()));
    rst_n = 1'b1;
    @(negedge clk);

`ifdef VIEW_ROT_EN
    run_req("t1", 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0000, 0, 0);
    check("t1_m3", u16(bus.view_matrix[3]), u16(16'hFF00));
    check("t1_m7", u16(bus.view_matrix[7]), u16(16'hFE00));
    check("t1_m11", u16(bus.view_matrix[11]), u16(16'hFD00));
    check("t1_diag", u16(bus.view_matrix[10]), u16(16'h0100));

    run_req("t2", 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 0, 0);
    check("t2_m2", u16(bus.view_matrix[2]), u16(16'h0100));
    check("t2_m8", u16(bus.view_matrix[8]), u16(16'hFF00));
    check("t2_m11", u16(bus.view_matrix[11]), u16(16'h0100));
    check("t2_m0", u16(bus.view_matrix[0]), u16(16'h0000));
    check("t2_ovf", 256'(bus.overflow), 256'(1'b0));

    run_req("t3", 16'h8000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 0, 0);
    check("t3_m3", u16(bus.view_matrix[3]), u16(16'h7FFF));
    check("t3_ovf", 256'(bus.overflow), 256'(1'b1));
    run_req("t3_clean", 16'h0040, 16'h0010, 16'hFFC0, 16'h00B5, 16'h00B5, 0, 0);
    check("t3_clean_ovf", 256'(bus.overflow), 256'(1'b0));
`else
    run_req("t6", 16'h0100, 16'h0200, 16'h0300, 16'h1234, 16'h5678, 0, 0);
    check("t6_m3", u16(bus.view_matrix[3]), u16(16'hFF00));
    check("t6_m7", u16(bus.view_matrix[7]), u16(16'hFE00));
    check("t6_m11", u16(bus.view_matrix[11]), u16(16'hFD00));
    check("t6_m15", u16(bus.view_matrix[15]), u16(16'h0100));
    run_req("t6_sat", 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    check("t6_sat_m3", u16(bus.view_matrix[3]), u16(16'h7FFF));
`endif

    run_req("t4_stall", 16'h0180, 16'hFF40, 16'h0220, 16'h00DD, 16'h0080, 10, 1);

    // Reset mid-computation (in MUL2 with rotation, in HOLD translate-only), overflow already set.
    bus.x_pos    = 16'h8000;
    bus.y_pos    = 16'h0000;
    bus.z_pos    = 16'h0000;
    bus.cos_yaw  = 16'h8000;
    bus.sin_yaw  = 16'h0000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat ((LAT == 6) ? 2 : 0) @(negedge clk);
    check("t5_pre", 256'({bus.in_ready, bus.overflow}), 256'(2'b01));
    rst_n = 1'b0;
    #1;
    check("t5_matrix", 256'(bus.view_matrix), 256'(ident_m()));
    check("t5_flags", 256'({bus.in_ready, bus.out_valid, bus.overflow}), 256'(3'b100));
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    run_req("t5_after", 16'h0300, 16'h0100, 16'hFE00, 16'h00F0, 16'hFFA0, 1, 0);

    for (int n = 0; n < 30; n++) begin
      in_t x, y, z, c, s;
      x = 16'($urandom);
      y = 16'($urandom);
      z = 16'($urandom);
      c = 16'($urandom);
      s = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        c = 16'($urandom_range(0, 512)) - 16'd256;
        s = 16'($urandom_range(0, 512)) - 16'd256;
        x = 16'($urandom_range(0, 4096)) - 16'd2048;
        z = 16'($urandom_range(0, 4096)) - 16'd2048;
      end
      run_req("rnd", x, y, z, c, s, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
